// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller slice.
package exc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2,
        HANDLER  = 2'd3
    } exc_state_t;

    localparam int unsigned CAUSE_PC       = 0;
    localparam int unsigned CAUSE_REG      = 1;
    localparam int unsigned CAUSE_OVF      = 2;
    localparam int unsigned CAUSE_MISALIGN = 3;
    localparam int unsigned CAUSE_DIV0     = 4;

    localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h0000_0080;

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder over the unmasked exception requests.
module exc_prio_enc #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned CAUSE_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] pending,
    output logic [CAUSE_W-1:0] sel,
    output logic               hit
);

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        hit = |pending;
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: gates commit, captures EPC/cause, sequences
// flush and redirect into the handler, and returns on eret.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CAUSE_W     = $clog2(NUM_SRC),
    parameter logic [ADDR_W-1:0] VECTOR_ADDR = ADDR_W'(DEFAULT_VECTOR_ADDR),
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] exc_req,
    input  logic [NUM_SRC-1:0] exc_mask,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               mem_write_in,
    input  logic               mem_2_reg_in,
    input  logic               eret,
    input  logic               clear_fault,
    output logic               enable,
    output logic               mem_write_out,
    output logic               mem_2_reg_out,
    output logic               flush,
    output logic               pc_redirect,
    output logic [ADDR_W-1:0]  redirect_addr,
    output logic [ADDR_W-1:0]  epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               cause_valid,
    output logic               double_fault,
    output logic               busy,
    output logic [CNT_W-1:0]   exc_count
);

    exc_state_t         state;
    exc_state_t         state_nxt;
    logic [NUM_SRC-1:0] pending;
    logic [CAUSE_W-1:0] sel;
    logic               hit;
    logic               accept;
    logic               nested;
    logic               ret;
    logic               suppress;

    assign pending = exc_req & ~exc_mask;

    exc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .CAUSE_W (CAUSE_W)
    ) u_prio_enc (
        .pending (pending),
        .sel     (sel),
        .hit     (hit)
    );

    assign accept = (state == IDLE) && hit;
    assign nested = (state == HANDLER) && hit;
    assign ret    = (state == HANDLER) && eret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (hit) state_nxt = FLUSH;
            FLUSH:    state_nxt = REDIRECT;
            REDIRECT: state_nxt = HANDLER;
            HANDLER:  if (eret) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Commit gating and redirect strobes; reset forces everything quiet.
    always_comb begin
        suppress      = hit || (state == FLUSH) || (state == REDIRECT);
        enable        = 1'b0;
        mem_write_out = 1'b0;
        mem_2_reg_out = 1'b0;
        flush         = 1'b0;
        pc_redirect   = 1'b0;
        redirect_addr = '0;
        busy          = (state != IDLE);
        if (!rst) begin
            enable        = ~suppress;
            mem_write_out = ~suppress & mem_write_in;
            mem_2_reg_out = ~suppress & mem_2_reg_in;
            flush         = (state == FLUSH);
            if (state == REDIRECT) begin
                pc_redirect   = 1'b1;
                redirect_addr = VECTOR_ADDR;
            end else if (ret) begin
                pc_redirect   = 1'b1;
                redirect_addr = epc + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc          <= '0;
            cause        <= '0;
            cause_valid  <= 1'b0;
            double_fault <= 1'b0;
            exc_count    <= '0;
        end else begin
            if (accept) begin
                epc         <= pc_in;
                cause       <= sel;
                cause_valid <= 1'b1;
                if (exc_count != '1) begin
                    exc_count <= exc_count + CNT_W'(1);
                end
            end else if (ret) begin
                cause_valid <= 1'b0;
            end
            // A nested fault outranks a coincident clear.
            if (nested) begin
                double_fault <= 1'b1;
            end else if (clear_fault) begin
                double_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  exc_req;
    logic [7:0]  exc_mask;
    logic [31:0] pc_in;
    logic        mem_write_in;
    logic        mem_2_reg_in;
    logic        eret;
    logic        clear_fault;
    logic        enable;
    logic        mem_write_out;
    logic        mem_2_reg_out;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        cause_valid;
    logic        double_fault;
    logic        busy;
    logic [7:0]  exc_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: cycles elapsed since an exception was accepted (-1 = none live).
    int          m_since;
    logic [31:0] m_epc;
    logic [2:0]  m_cause;
    logic        m_cv;
    logic        m_df;
    int          m_cnt;

    exception_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .exc_req       (exc_req),
        .exc_mask      (exc_mask),
        .pc_in         (pc_in),
        .mem_write_in  (mem_write_in),
        .mem_2_reg_in  (mem_2_reg_in),
        .eret          (eret),
        .clear_fault   (clear_fault),
        .enable        (enable),
        .mem_write_out (mem_write_out),
        .mem_2_reg_out (mem_2_reg_out),
        .flush         (flush),
        .pc_redirect   (pc_redirect),
        .redirect_addr (redirect_addr),
        .epc           (epc),
        .cause         (cause),
        .cause_valid   (cause_valid),
        .double_fault  (double_fault),
        .busy          (busy),
        .exc_count     (exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_since = -1;
        m_epc   = '0;
        m_cause = '0;
        m_cv    = 1'b0;
        m_df    = 1'b0;
        m_cnt   = 0;
    endtask

    function automatic int lowest_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_check();
        logic [7:0]  pend;
        logic        hit, in_handler, sup, redir;
        logic [31:0] addr;
        pend       = exc_req & ~exc_mask;
        hit        = (pend != 8'h00);
        in_handler = (m_since >= 2);
        sup        = hit || m_since == 0 || m_since == 1;
        redir      = (m_since == 1) || (in_handler && eret);
        addr       = (m_since == 1) ? VEC : ((in_handler && eret) ? m_epc + 32'd4 : 32'd0);
        if (rst) begin
            chk("enable", 32'(enable), 32'd0);
            chk("mem_write_out", 32'(mem_write_out), 32'd0);
            chk("mem_2_reg_out", 32'(mem_2_reg_out), 32'd0);
            chk("flush", 32'(flush), 32'd0);
            chk("pc_redirect", 32'(pc_redirect), 32'd0);
            chk("redirect_addr", redirect_addr, 32'd0);
        end else begin
            chk("enable", 32'(enable), 32'(!sup));
            chk("mem_write_out", 32'(mem_write_out), 32'(!sup && mem_write_in));
            chk("mem_2_reg_out", 32'(mem_2_reg_out), 32'(!sup && mem_2_reg_in));
            chk("flush", 32'(flush), 32'(m_since == 0));
            chk("pc_redirect", 32'(pc_redirect), 32'(redir));
            chk("redirect_addr", redirect_addr, addr);
        end
        chk("epc", epc, m_epc);
        chk("cause", 32'(cause), 32'(m_cause));
        chk("cause_valid", 32'(cause_valid), 32'(m_cv));
        chk("double_fault", 32'(double_fault), 32'(m_df));
        chk("busy", 32'(busy), 32'(m_since >= 0));
        chk("exc_count", 32'(exc_count), 32'(m_cnt));
    endtask

    task automatic model_update();
        logic [7:0] pend;
        logic       hit;
        if (rst) begin
            model_reset();
            return;
        end
        pend = exc_req & ~exc_mask;
        hit  = (pend != 8'h00);
        if (m_since >= 2 && hit) m_df = 1'b1;
        else if (clear_fault)    m_df = 1'b0;
        if (m_since < 0) begin
            if (hit) begin
                m_epc   = pc_in;
                m_cause = 3'(lowest_set(pend));
                m_cv    = 1'b1;
                m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_since = 0;
            end
        end else if (m_since < 2) begin
            m_since++;
        end else if (eret) begin
            m_cv    = 1'b0;
            m_since = -1;
        end else begin
            m_since++;
        end
    endtask

    // Drive one cycle's inputs, then compare against the model.
    task automatic apply(input logic [7:0] r, input logic [7:0] m, input logic [31:0] pc,
                         input logic w, input logic l, input logic e, input logic c);
        exc_req      = r;
        exc_mask     = m;
        pc_in        = pc;
        mem_write_in = w;
        mem_2_reg_in = l;
        eret         = e;
        clear_fault  = c;
        #1;
        model_check();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        apply(8'h00, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        apply(8'h00, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset release, no requests.
        apply(8'h00, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_rel_enable", 32'(enable), 32'd1);
        chk("lit_rel_mw", 32'(mem_write_out), 32'd1);
        chk("lit_rel_busy", 32'(busy), 32'd0);
        chk("lit_rel_cnt", 32'(exc_count), 32'd0);
        advance();

        // Overflow exception at 0x40.
        apply(8'b0000_0100, 8'h00, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("lit_exc_enable", 32'(enable), 32'd0);
        chk("lit_exc_mw", 32'(mem_write_out), 32'd0);
        advance();
        apply(8'h00, 8'h00, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_flush", 32'(flush), 32'd1);
        advance();
        apply(8'h00, 8'h00, 32'h48, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_redir", 32'(pc_redirect), 32'd1);
        chk("lit_redir_addr", redirect_addr, 32'h80);
        advance();
        apply(8'h00, 8'h00, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_epc", epc, 32'h40);
        chk("lit_cause", 32'(cause), 32'd2);
        chk("lit_cnt1", 32'(exc_count), 32'd1);
        chk("lit_handler_enable", 32'(enable), 32'd1);
        advance();

        // Nested fault inside the handler, then return.
        apply(8'h01, 8'h00, 32'h84, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_nested_enable", 32'(enable), 32'd0);
        advance();
        apply(8'h00, 8'h00, 32'h88, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_df", 32'(double_fault), 32'd1);
        chk("lit_df_epc", epc, 32'h40);
        chk("lit_eret_redir", 32'(pc_redirect), 32'd1);
        chk("lit_eret_addr", redirect_addr, 32'h44);
        advance();
        apply(8'h00, 8'h00, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lit_ret_busy", 32'(busy), 32'd0);
        chk("lit_ret_cv", 32'(cause_valid), 32'd0);
        advance();
        apply(8'h00, 8'h00, 32'h48, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_clr_df", 32'(double_fault), 32'd0);
        chk("lit_idle_eret", 32'(pc_redirect), 32'd0);
        advance();
        apply(8'h00, 8'h00, 32'h4c, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_idle_eret_busy", 32'(busy), 32'd0);
        advance();

        // Masking: bit 3 masked, bit 4 wins.
        apply(8'b0001_1000, 8'b0000_1000, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        idle_cycle();
        idle_cycle();
        apply(8'h00, 8'h00, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lit_mask_cause", 32'(cause), 32'd4);
        chk("lit_mask_epc", epc, 32'h100);
        advance();
        apply(8'b0000_1000, 8'b0000_1000, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lit_masked_enable", 32'(enable), 32'd1);
        advance();
        apply(8'h00, 8'h00, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_masked_busy", 32'(busy), 32'd0);
        advance();

        // Reset asserted while flushing.
        apply(8'h01, 8'h00, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        apply(8'h00, 8'h00, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_pre_rst_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("lit_rst_flush", 32'(flush), 32'd0);
        chk("lit_rst_busy", 32'(busy), 32'd0);
        chk("lit_rst_cv", 32'(cause_valid), 32'd0);
        model_reset();
        model_check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Saturation: 256 accepted exceptions.
        for (int k = 0; k < 256; k++) begin
            apply(8'h02, 8'h00, 32'(k * 4), 1'b1, 1'b0, 1'b0, 1'b0);
            advance();
            idle_cycle();
            idle_cycle();
            apply(8'h00, 8'h00, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0);
            advance();
        end
        apply(8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lit_sat_cnt", 32'(exc_count), 32'd255);
        advance();

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            apply(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                  8'($urandom) & 8'($urandom) & 8'($urandom),
                  $urandom & 32'hffff_fffc,
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) == 0);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
Parametrised, stateful successor to the combinational commit-gating error logic. Collects NUM_SRC exception requests (PC fault, register error, ALU overflow/misaligned/divide-by-zero, …) and applies a per-source mask. It suppresses the faulting instruction's memory/register commit, captures EPC and cause, and sequences a flush/redirect into the handler vector. It returns on eret and sits between decode/execute status outputs and the memory/writeback enables.

Parameters:
NUM_SRC, 8, number of exception request lines; bit 0 is highest priority
ADDR_W, 32, PC/EPC width
CAUSE_W, $clog2(NUM_SRC), cause code width
VECTOR_ADDR, 32'h0000_0080, handler entry address
CNT_W, 8, width of saturating exception counter

Ports:
clk  in  1  system clock
rst  in  1  reset
exc_req  in  NUM_SRC  raw exception requests for the instruction in the commit stage
exc_mask  in  NUM_SRC  1 = source masked (ignored)
pc_in  in  ADDR_W  PC of the instruction in the commit stage
mem_write_in  in  1  instruction's memory-write request
mem_2_reg_in  in  1  instruction's load-writeback select
eret  in  1  return-from-exception strobe
clear_fault  in  1  clears double_fault
enable  out  1  register-file/commit enable
mem_write_out  out  1  gated memory write
mem_2_reg_out  out  1  gated writeback select
flush  out  1  pipeline flush strobe
pc_redirect  out  1  PC load strobe
redirect_addr  out  ADDR_W  PC load value
epc  out  ADDR_W  captured faulting PC
cause  out  CAUSE_W  captured source index
cause_valid  out  1  epc/cause hold a live exception
double_fault  out  1  sticky; exception raised inside handler
busy  out  1  state != IDLE
exc_count  out  CNT_W  saturating count of accepted exceptions

Behaviour:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset state: IDLE; epc=0, cause=0, cause_valid=0, double_fault=0, exc_count=0. While rst is high: enable=0, mem_write_out=0, mem_2_reg_out=0, flush=0, pc_redirect=0, redirect_addr=0.
- pending = exc_req & ~exc_mask; hit = |pending; sel = lowest set index of pending.
- Commit gating (combinational, same cycle):
  - suppress = hit OR state in {FLUSH, REDIRECT}.
  - enable = ~suppress. mem_write_out = suppress ? 0 : mem_write_in. mem_2_reg_out = suppress ? 0 : mem_2_reg_in. Outputs are never X.
- IDLE:
  - On hit: epc<=pc_in, cause<=sel, cause_valid<=1, exc_count<=sat(exc_count+1). Next state FLUSH.
  - eret in IDLE is ignored.
- FLUSH: 1 cycle; flush=1; exc_req and eret ignored. Next state REDIRECT.
- REDIRECT: 1 cycle; pc_redirect=1, redirect_addr=VECTOR_ADDR; requests and eret ignored. Next state HANDLER.
- HANDLER: handler instructions commit normally.
  - hit: that instruction is suppressed, double_fault<=1; epc, cause and exc_count are unchanged; no nesting.
  - eret: pc_redirect=1, redirect_addr=epc+4 (mod 2^ADDR_W) in the same cycle; cause_valid<=0 (epc and cause retained). Next state IDLE.
  - hit and eret together: both actions apply.
- clear_fault clears double_fault next cycle. If set and clear coincide, set wins.
- exc_count saturates at 2^CNT_W-1 and never wraps.
- busy = (state != IDLE), combinational.
- Latency: request to flush = 1 cycle; request to redirect = 2 cycles; eret to redirect = 0 cycles.

Decomposition:
- Package exc_pkg holds:
  - state enum {IDLE, FLUSH, REDIRECT, HANDLER};
  - cause constants CAUSE_PC=0, CAUSE_REG=1, CAUSE_OVF=2, CAUSE_MISALIGN=3, CAUSE_DIV0=4;
  - default VECTOR_ADDR.
- Sub-module exc_prio_enc: parametrised lowest-index priority encoder (pending -> sel, hit).

Test Plan:
- Reset release, no requests, mem_write_in=1 -> enable=1, mem_write_out=1, busy=0, exc_count=0.
- exc_req=8'b0000_0100, pc_in=0x40, mem_write_in=1 -> that cycle enable=0, mem_write_out=0. Next cycle flush=1. Cycle after: pc_redirect=1, redirect_addr=0x80. Then epc=0x40, cause=2, exc_count=1.
- exc_req=8'b0001_1000, exc_mask=8'b0000_1000 -> cause=4. Repeat with exc_req=8'b0000_1000 alone (masked) -> no response, enable=1.
- In HANDLER, exc_req=1 -> double_fault=1, epc unchanged. Then eret -> pc_redirect=1, redirect_addr=0x44, state IDLE. Then clear_fault -> double_fault=0.
- rst asserted in FLUSH -> immediately state IDLE, flush=0, cause_valid=0. Also check eret in IDLE has no effect.
- Force 256 exceptions with CNT_W=8 -> exc_count holds 255.
